// File: rtl/blake2_pkg.sv
// Shared definitions for the blake2 core and its host-side feeder.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package blake2_pkg;

  // BLAKE2s block size in bytes; the core's byte index is 6 bits wide.
  localparam int BLOCK_BYTES = 64;
  localparam int IDX_W       = 6;

  // Default widths of kk/nn and ll, matching the core's W_CLOG2_P1 and BB.
  localparam int KW_DEF  = 6;
  localparam int LLW_DEF = 64;

  // Feeder sequencing: key block, key padding, message, message padding,
  // then digest capture/replay.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    KEY  = 3'd1,
    KPAD = 3'd2,
    MSG  = 3'd3,
    MPAD = 3'd4,
    RES  = 3'd5
  } feeder_state_t;

endpackage

// File: rtl/blake2_res_buf.sv
// Digest capture buffer: NN_MAX x 8 registers, filled by an unthrottled burst, replayed over valid/ready.
// Latency: a written byte is visible on m_valid the cycle after its write.
// Backpressure: writes are never blocked (capped at nn); reads stall on m_ready.
module blake2_res_buf
  import blake2_pkg::*;
#(
  parameter int NN_MAX = 32,
  parameter int KW     = KW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [KW-1:0] nn,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          m_valid,
  output logic [7:0]    m_data,
  output logic          m_last,
  input  logic          m_ready,
  output logic          done
);

  localparam int AW = (NN_MAX > 1) ? $clog2(NN_MAX) : 1;

  logic [7:0]    mem_q [NN_MAX];
  logic [KW-1:0] wr_q;
  logic [KW-1:0] rd_q;
  logic          wr_ok;
  logic          hs;

  // Read port and write qualification; writes beyond nn (or the array) are dropped.
  always_comb begin
    wr_ok   = wr_en & (wr_q < nn) & (wr_q < KW'(NN_MAX));
    m_valid = (rd_q < wr_q);
    m_data  = mem_q[rd_q[AW-1:0]];
    m_last  = m_valid & (rd_q == nn - KW'(1));
    hs      = m_valid & m_ready;
    done    = hs & m_last;
  end

  // Pointers: advance on write/handshake, both cleared once the final byte is taken.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else if (done) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (wr_ok) wr_q <= wr_q + KW'(1);
      if (hs)    rd_q <= rd_q + KW'(1);
    end
  end

  // Storage: cleared on reset so the idle read port shows zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NN_MAX; i++) mem_q[i] <= '0;
    end else if (wr_ok) begin
      mem_q[wr_q[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/blake2_feeder.sv
// Host-side feeder for blake2 (BLAKE2s): frames key/message bytes into zero-padded 64-byte blocks, buffers the digest.
// Latency: byte path to the core is combinational; first digest byte valid 2 cycles after the first h_v beat.
// Backpressure: stalls purely on core_ready_i upstream; digest replay stalls on m_ready_i.
// Keyed hashing is compiled in only when BLAKE2_FEEDER_KEY_EN is defined; otherwise kk is forced to 0.
module blake2_feeder
  import blake2_pkg::*;
#(
  parameter int NN_MAX = 32,
  parameter int KW     = KW_DEF,
  parameter int LLW    = LLW_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [KW-1:0]    kk_i,
  input  logic [KW-1:0]    nn_i,
  input  logic [LLW-1:0]   ll_i,
  output logic             busy_o,
  input  logic             s_valid_i,
  input  logic [7:0]       s_data_i,
  output logic             s_ready_o,
  input  logic             core_ready_i,
  output logic             core_data_v_o,
  output logic [IDX_W-1:0] core_data_idx_o,
  output logic [7:0]       core_data_o,
  output logic             core_block_first_o,
  output logic             core_block_last_o,
  output logic [KW-1:0]    core_kk_o,
  output logic [KW-1:0]    core_nn_o,
  output logic [LLW-1:0]   core_ll_o,
  input  logic             core_h_v_i,
  input  logic [7:0]       core_h_i,
  output logic             m_valid_o,
  output logic [7:0]       m_data_o,
  output logic             m_last_o,
  input  logic             m_ready_i
);

  feeder_state_t state_q, state_n;

  logic [KW-1:0]    kk_q;
  logic [KW-1:0]    nn_q;
  logic [LLW-1:0]   ll_q;
  logic [LLW-1:0]   core_ll_q;
  logic [LLW-1:0]   nblk_q;
  logic [LLW-1:0]   blk_cnt_q;
  logic [LLW-1:0]   cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic             stale_seen_q;

  logic [KW-1:0]    kk_eff;
  logic             key_on;
  logic [LLW-1:0]   msg_blks;
  logic [LLW-1:0]   nblk_d;
  logic [LLW-1:0]   core_ll_d;

  logic             data_state;
  logic             pad_state;
  logic             feed_state;
  logic             xfer;
  logic             data_xfer;
  logic             blk_end;
  logic             key_done;
  logic             msg_done;
  logic             buf_wr;
  logic             buf_done;

`ifdef BLAKE2_FEEDER_KEY_EN
  assign kk_eff = kk_i;
`else
  logic unused_kk;
  assign kk_eff    = '0;
  assign unused_kk = ^kk_i;
`endif

  // Start-time configuration: block count and length seen by the core, including the key block.
  always_comb begin
    key_on    = (kk_eff != '0);
    msg_blks  = (ll_i == '0) ? {{(LLW-1){1'b0}}, ~key_on}
                             : (ll_i >> IDX_W) + {{(LLW-1){1'b0}}, |ll_i[IDX_W-1:0]};
    nblk_d    = msg_blks + {{(LLW-1){1'b0}}, key_on};
    core_ll_d = ll_i + (key_on ? LLW'(BLOCK_BYTES) : '0);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // Next state plus the combinational byte path towards the core.
  always_comb begin
    state_n            = state_q;
    data_state         = (state_q == KEY) || (state_q == MSG);
    pad_state          = (state_q == KPAD) || (state_q == MPAD);
    feed_state         = data_state || pad_state;
    s_ready_o          = core_ready_i & data_state;
    xfer               = core_ready_i & ((s_valid_i & s_ready_o) | pad_state);
    data_xfer          = xfer & data_state;
    blk_end            = xfer & (idx_q == IDX_W'(BLOCK_BYTES - 1));
    key_done           = data_xfer & (state_q == KEY) & (cnt_q + LLW'(1) == LLW'(kk_q));
    msg_done           = data_xfer & (state_q == MSG) & (cnt_q + LLW'(1) == ll_q);
    core_data_v_o      = xfer;
    core_data_idx_o    = idx_q;
    core_data_o        = data_state ? s_data_i : 8'h00;
    core_block_first_o = feed_state & (blk_cnt_q == '0);
    core_block_last_o  = feed_state & (blk_cnt_q == nblk_q - LLW'(1));
    busy_o             = (state_q != IDLE);
    buf_wr             = (state_q == RES) & core_h_v_i & stale_seen_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
`ifdef BLAKE2_FEEDER_KEY_EN
          if (key_on)             state_n = KEY;
          else
`endif
          if (ll_i == '0)         state_n = MPAD;
          else                    state_n = MSG;
        end
      end
`ifdef BLAKE2_FEEDER_KEY_EN
      KEY: begin
        if (key_done) state_n = KPAD;
      end
      KPAD: begin
        if (blk_end) state_n = (nblk_q == LLW'(1)) ? RES : MSG;
      end
`endif
      MSG: begin
        // A final byte landing on idx 63 completes the block: no padding needed.
        if (msg_done) state_n = (idx_q == IDX_W'(BLOCK_BYTES - 1)) ? RES : MPAD;
      end
      MPAD: begin
        if (blk_end) state_n = RES;
      end
      RES: begin
        if (buf_done) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Configuration latch, byte index, block and byte counters, stale-beat tracking.
  always_ff @(posedge clk) begin
    if (reset) begin
      kk_q         <= '0;
      nn_q         <= '0;
      ll_q         <= '0;
      core_ll_q    <= '0;
      nblk_q       <= '0;
      blk_cnt_q    <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      stale_seen_q <= 1'b0;
    end else if ((state_q == IDLE) && start_i) begin
      kk_q         <= kk_eff;
      nn_q         <= nn_i;
      ll_q         <= ll_i;
      core_ll_q    <= core_ll_d;
      nblk_q       <= nblk_d;
      blk_cnt_q    <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      stale_seen_q <= 1'b0;
    end else begin
      if (xfer) begin
        idx_q <= idx_q + IDX_W'(1);
        if (idx_q == IDX_W'(BLOCK_BYTES - 1)) blk_cnt_q <= blk_cnt_q + LLW'(1);
      end
      // The same counter tracks key bytes, then message bytes.
      if (key_done)       cnt_q <= '0;
      else if (data_xfer) cnt_q <= cnt_q + LLW'(1);
      // The core raises h_v one cycle early; the first beat of the burst is discarded.
      if ((state_q == RES) && core_h_v_i) stale_seen_q <= 1'b1;
    end
  end

  assign core_kk_o = kk_q;
  assign core_nn_o = nn_q;
  assign core_ll_o = core_ll_q;

  blake2_res_buf #(
    .NN_MAX (NN_MAX),
    .KW     (KW)
  ) u_res_buf (
    .clk     (clk),
    .reset   (reset),
    .nn      (nn_q),
    .wr_en   (buf_wr),
    .wr_data (core_h_i),
    .m_valid (m_valid_o),
    .m_data  (m_data_o),
    .m_last  (m_last_o),
    .m_ready (m_ready_i),
    .done    (buf_done)
  );

endmodule

// File: tb/tb_blake2_feeder.sv
// Bench for blake2_feeder: plays the core (ready stalls, digest burst) and the host.
// Expected block streams are built from the padding rules on byte queues.
module tb_blake2_feeder;

  localparam int NN_MAX = 32;
  localparam int KW     = 6;
  localparam int LLW    = 64;
`ifdef BLAKE2_FEEDER_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic           start_i;
  logic [KW-1:0]  kk_i, nn_i;
  logic [LLW-1:0] ll_i;
  logic           busy_o;
  logic           s_valid_i;
  logic [7:0]     s_data_i;
  logic           s_ready_o;
  logic           core_ready_i;
  logic           core_data_v_o;
  logic [5:0]     core_data_idx_o;
  logic [7:0]     core_data_o;
  logic           core_block_first_o, core_block_last_o;
  logic [KW-1:0]  core_kk_o, core_nn_o;
  logic [LLW-1:0] core_ll_o;
  logic           core_h_v_i;
  logic [7:0]     core_h_i;
  logic           m_valid_o;
  logic [7:0]     m_data_o;
  logic           m_last_o;
  logic           m_ready_i;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  blake2_feeder #(.NN_MAX(NN_MAX), .KW(KW), .LLW(LLW)) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .kk_i(kk_i), .nn_i(nn_i), .ll_i(ll_i),
    .busy_o(busy_o), .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_ready_o(s_ready_o),
    .core_ready_i(core_ready_i), .core_data_v_o(core_data_v_o), .core_data_idx_o(core_data_idx_o),
    .core_data_o(core_data_o), .core_block_first_o(core_block_first_o),
    .core_block_last_o(core_block_last_o), .core_kk_o(core_kk_o), .core_nn_o(core_nn_o),
    .core_ll_o(core_ll_o), .core_h_v_i(core_h_v_i), .core_h_i(core_h_i),
    .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i)
  );

  int total = 0;
  int bad   = 0;

  logic [7:0] key_q[$];
  logic [7:0] msg_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fill_msg(input int n, input bit abc);
    msg_q.delete();
    key_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(abc ? 8'(8'h61 + i) : 8'($urandom));
    for (int i = 0; i < 32; i++) key_q.push_back(8'($urandom));
  endtask

  // One full hash: start, feed bytes as the core, emit the digest burst, drain as the host.
  // Enters and leaves one time unit after a rising edge.
  task automatic run_hash(input int kk_in, input int nn_in, input logic [63:0] ll_in,
                          input int mr_mode, input int stall_len, input int abort_at,
                          output int blocks, output logic [63:0] ll_seen);
    logic [7:0]  src[$];
    logic [7:0]  strm[$];
    logic [7:0]  hq[$];
    logic [7:0]  beats[$];
    logic [63:0] exp_ll;
    int kke, nblk, sent, srcpos, stall, got, hidx, hwait, first_h, first_mv;
    bit fin;

    kke = KEY_EN ? kk_in : 0;
    for (int i = 0; i < kke; i++) begin src.push_back(key_q[i]); strm.push_back(key_q[i]); end
    if (kke > 0) while (strm.size() % 64 != 0) strm.push_back(8'h00);
    for (int i = 0; i < msg_q.size(); i++) begin src.push_back(msg_q[i]); strm.push_back(msg_q[i]); end
    if (strm.size() == 0) repeat (64) strm.push_back(8'h00);
    while (strm.size() % 64 != 0) strm.push_back(8'h00);
    nblk   = strm.size() / 64;
    exp_ll = ll_in + ((kke > 0) ? 64'd64 : 64'd0);
    for (int i = 0; i < nn_in; i++) hq.push_back(8'($urandom));
    beats.push_back(~hq[0]);
    for (int i = 0; i < nn_in; i++) beats.push_back(hq[i]);
    beats.push_back(8'($urandom));
    beats.push_back(8'($urandom));

    kk_i = KW'(kk_in); nn_i = KW'(nn_in); ll_i = ll_in; start_i = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
    check("busy_after_start", {63'd0, busy_o}, 64'd1);
    check("core_nn", {58'd0, core_nn_o}, 64'(nn_in));
    check("core_kk", {58'd0, core_kk_o}, 64'(kke));
    ll_seen = core_ll_o;

    sent = 0; srcpos = 0; stall = 0; got = 0; hidx = 0; hwait = 0;
    first_h = -1; first_mv = -1; fin = 1'b0; blocks = 0;
    for (int c = 0; c < 20000 && !fin; c++) begin
      if (abort_at >= 0 && sent == abort_at) begin
        reset = 1'b1; core_ready_i = 1'b1; s_valid_i = 1'b1; m_ready_i = 1'b1;
        core_h_v_i = 1'b0; start_i = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_s_ready", {63'd0, s_ready_o}, 64'd0);
        check("abort_m_valid", {63'd0, m_valid_o}, 64'd0);
        check("abort_data_v", {63'd0, core_data_v_o}, 64'd0);
        check("abort_first", {63'd0, core_block_first_o}, 64'd0);
        check("abort_core_ll", core_ll_o, 64'd0);
        return;
      end
      core_ready_i = (stall == 0);
      if (stall > 0) stall--;
      s_valid_i = ($urandom_range(0, 3) != 0);
      s_data_i  = (srcpos < src.size()) ? src[srcpos] : 8'($urandom);
      start_i   = (sent == 10);
      ll_i      = (sent == 10) ? ~ll_in : ll_in;
      nn_i      = (sent == 10) ? KW'(nn_in ^ 1) : KW'(nn_in);
      m_ready_i = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
      core_h_v_i = 1'b0;
      core_h_i   = 8'h00;
      if (sent == strm.size()) begin
        if (hwait < 3) hwait++;
        else if (hidx < beats.size()) begin
          if (hidx == 0) first_h = cyc;
          core_h_v_i = 1'b1;
          core_h_i   = beats[hidx];
          hidx++;
        end
      end

      @(negedge clk);
      if (s_ready_o && !core_ready_i) check("s_ready_without_core_ready", 64'd1, 64'd0);
      if (s_ready_o && s_valid_i) begin
        if (srcpos >= src.size()) check("upstream_overrun", 64'(srcpos), 64'(src.size() - 1));
        srcpos++;
      end
      if (core_data_v_o) begin
        if (sent >= strm.size()) check("extra_core_byte", 64'(sent), 64'(strm.size() - 1));
        else begin
          check("core_byte",
                {48'd0, core_data_idx_o, core_data_o, core_block_first_o, core_block_last_o},
                {48'd0, 6'(sent % 64), strm[sent], 1'(sent / 64 == 0), 1'(sent / 64 == nblk - 1)});
          if (sent % 64 == 63) begin blocks++; stall = stall_len; end
        end
        sent++;
      end
      if (m_valid_o) begin
        if (first_mv < 0) begin
          first_mv = cyc;
          check("digest_latency", 64'(first_mv), 64'(first_h + 2));
        end
        if (m_ready_i) begin
          if (got < nn_in) begin
            check("digest_byte", {55'd0, m_last_o, m_data_o}, {55'd0, 1'(got == nn_in - 1), hq[got]});
          end else check("digest_overrun", 64'(got), 64'(nn_in - 1));
          got++;
        end
      end
      @(posedge clk); #1;
      if (got == nn_in) begin
        fin = 1'b1;
        check("idle_after_digest", {63'd0, busy_o}, 64'd0);
        check("core_ll_held", core_ll_o, exp_ll);
        check("core_nn_held", {58'd0, core_nn_o}, 64'(nn_in));
      end
    end
    core_h_v_i = 1'b0; m_ready_i = 1'b0; s_valid_i = 1'b0;
    if (!fin) begin
      total++; bad++;
      $display("FAIL timeout: sent=%0d digest_bytes=%0d required %0d/%0d", sent, got, strm.size(), nn_in);
    end
    check("stream_len", 64'(sent), 64'(strm.size()));
    check("upstream_consumed", 64'(srcpos), 64'(src.size()));
  endtask

  typedef struct {
    int          kk;
    int          nn;
    int          ll;
    bit          abc;
    int          mr;
    int          stall;
    int          exp_blocks;
    logic [63:0] exp_ll;
  } vec_t;

  vec_t vt[9];

  initial begin
    int          blocks;
    logic [63:0] llv;

    vt[0] = '{kk: 0,  nn: 32, ll: 0,   abc: 0, mr: 0, stall: 97, exp_blocks: 1, exp_ll: 64'd0};
    vt[1] = '{kk: 0,  nn: 32, ll: 3,   abc: 1, mr: 0, stall: 3,  exp_blocks: 1, exp_ll: 64'd3};
    vt[2] = '{kk: 0,  nn: 32, ll: 64,  abc: 0, mr: 2, stall: 2,  exp_blocks: 1, exp_ll: 64'd64};
    vt[3] = '{kk: 0,  nn: 32, ll: 65,  abc: 0, mr: 0, stall: 97, exp_blocks: 2, exp_ll: 64'd65};
    vt[4] = '{kk: 0,  nn: 32, ll: 3,   abc: 1, mr: 1, stall: 1,  exp_blocks: 1, exp_ll: 64'd3};
    vt[5] = '{kk: 0,  nn: 1,  ll: 130, abc: 0, mr: 2, stall: 4,  exp_blocks: 3, exp_ll: 64'd130};
    vt[8] = '{kk: 0,  nn: 5,  ll: 128, abc: 0, mr: 2, stall: 0,  exp_blocks: 2, exp_ll: 64'd128};
`ifdef BLAKE2_FEEDER_KEY_EN
    vt[6] = '{kk: 32, nn: 32, ll: 0,   abc: 0, mr: 0, stall: 5,  exp_blocks: 1, exp_ll: 64'd64};
    vt[7] = '{kk: 32, nn: 20, ll: 100, abc: 0, mr: 2, stall: 3,  exp_blocks: 3, exp_ll: 64'd164};
`else
    vt[6] = '{kk: 32, nn: 32, ll: 0,   abc: 0, mr: 0, stall: 5,  exp_blocks: 1, exp_ll: 64'd0};
    vt[7] = '{kk: 32, nn: 20, ll: 100, abc: 0, mr: 2, stall: 3,  exp_blocks: 2, exp_ll: 64'd100};
`endif

    reset = 1'b1; start_i = 1'b0; kk_i = '0; nn_i = '0; ll_i = '0;
    s_valid_i = 1'b1; s_data_i = 8'hA5; core_ready_i = 1'b1;
    core_h_v_i = 1'b0; core_h_i = 8'h00; m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_s_ready", {63'd0, s_ready_o}, 64'd0);
    check("rst_data_v", {63'd0, core_data_v_o}, 64'd0);
    check("rst_flags_idx", {56'd0, core_block_first_o, core_block_last_o, core_data_idx_o}, 64'd0);
    check("rst_cfg", core_ll_o | {58'd0, core_kk_o} | {58'd0, core_nn_o}, 64'd0);
    check("rst_m_port", {54'd0, m_valid_o, m_last_o, m_data_o}, 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 9; v++) begin
      fill_msg(vt[v].ll, vt[v].abc);
      run_hash(vt[v].kk, vt[v].nn, 64'(vt[v].ll), vt[v].mr, vt[v].stall, -1, blocks, llv);
      check($sformatf("vec%0d_blocks", v), 64'(blocks), 64'(vt[v].exp_blocks));
      check($sformatf("vec%0d_core_ll", v), llv, vt[v].exp_ll);
    end

    // Reset at byte 30 of the second block, then a fresh "abc" run.
    fill_msg(200, 1'b0);
    run_hash(0, 32, 64'd200, 0, 2, 94, blocks, llv);
    check("abort_blocks_done", 64'(blocks), 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("post_abort_idle", {63'd0, busy_o}, 64'd0);
    fill_msg(3, 1'b1);
    run_hash(0, 32, 64'd3, 1, 97, -1, blocks, llv);
    check("post_abort_blocks", 64'(blocks), 64'd1);
    check("post_abort_core_ll", llv, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
